// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// R-type funct codes, ALU operation classes and ALU control codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2,
    ALUOP_IMM   = 2'd3
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2a;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic logic is_ext_op(input logic [5:0] op);
    return (op == OP_BNE) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's operation class plus op/funct to a 3-bit ALU
// control code, and flags whether funct names a supported R-type operation.
module mc_aludec
  import mc_ctrl_pkg::*;
(
  input  aluop_t     aluop_i,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o,
  output logic       funct_valid_o
);

  // Kept separate from the code mux so it depends on funct alone.
  assign funct_valid_o = (funct_i == F_ADD) || (funct_i == F_SUB) ||
                         (funct_i == F_AND) || (funct_i == F_OR)  ||
                         (funct_i == F_SLT);

  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALU_ADD;
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          F_SUB:   alucontrol_o = ALU_SUB;
          F_AND:   alucontrol_o = ALU_AND;
          F_OR:    alucontrol_o = ALU_OR;
          F_SLT:   alucontrol_o = ALU_SLT;
          default: alucontrol_o = ALU_ADD;
        endcase
      end
      ALUOP_IMM: begin
        case (op_i)
          OP_ANDI: alucontrol_o = ALU_AND;
          OP_ORI:  alucontrol_o = ALU_OR;
          OP_SLTI: alucontrol_o = ALU_SLT;
          default: alucontrol_o = ALU_ADD;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller_ext.sv
// Multicycle MIPS control unit: state register, next-state logic and
// combinational strobe decode, with optional memory wait-state handshake.
module mc_controller_ext
  import mc_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit ENABLE_EXT    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       immext,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_q, state_d;
  aluop_t aluop;
  logic   mem_rdy, funct_valid, op_ok;
  logic   pcwrite, branch, bne_br;

  assign mem_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  mc_aludec u_aludec (
    .aluop_i       (aluop),
    .op_i          (op),
    .funct_i       (funct),
    .alucontrol_o  (alucontrol),
    .funct_valid_o (funct_valid)
  );

  always_comb begin
    op_ok = 1'b0;
    case (op)
      OP_RTYPE:                       op_ok = funct_valid;
      OP_LW, OP_SW, OP_ADDI,
      OP_BEQ, OP_J:                   op_ok = 1'b1;
      default:                        op_ok = ENABLE_EXT && is_ext_op(op);
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        state_d = S_FETCH;
        if (op_ok) begin
          case (op)
            OP_LW, OP_SW:                     state_d = S_MEMADR;
            OP_RTYPE:                         state_d = S_RTYPEEX;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMMEX;
            OP_BEQ:                           state_d = S_BEQEX;
            OP_BNE:                           state_d = S_BNEEX;
            OP_J:                             state_d = S_JEX;
            default:                          state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_rdy ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_IMMEX:   state_d = S_IMMWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    bne_br   = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    immext   = 1'b0;
    pcsrc    = 2'b00;
    aluop    = ALUOP_ADD;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_rdy;
        pcwrite = mem_rdy;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        illegal = ~op_ok;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = ALUOP_IMM;
        immext  = (op == OP_ANDI) || (op == OP_ORI);
      end
      S_IMMWB: regwrite = 1'b1;
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_BNEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        bne_br  = 1'b1;
      end
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcen  = pcwrite | (branch & zero) | (bne_br & ~zero);
  assign state = state_q;

endmodule

// File: tb/tb_mc_controller_ext.sv
// Directed bench for mc_controller_ext: walks each instruction class through
// the FSM and checks states and strobes against hand-derived values.
module tb_mc_controller_ext;

  logic       clk, reset, zero, mem_ready;
  logic [5:0] op, funct;
  logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, immext, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic       pcen_n, memwrite_n, irwrite_n, regwrite_n, alusrca_n, iord_n, memtoreg_n, regdst_n, immext_n, illegal_n;
  logic [1:0] alusrcb_n, pcsrc_n;
  logic [2:0] alucontrol_n;
  logic [3:0] state_n;

  int n_cmp = 0;
  int n_err = 0;

  mc_controller_ext dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .iord(iord), .memtoreg(memtoreg),
    .regdst(regdst), .immext(immext), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .illegal(illegal), .state(state)
  );

  mc_controller_ext #(.ENABLE_EXT(1'b0)) u_noext (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen_n), .memwrite(memwrite_n), .irwrite(irwrite_n), .regwrite(regwrite_n),
    .alusrca(alusrca_n), .alusrcb(alusrcb_n), .iord(iord_n), .memtoreg(memtoreg_n),
    .regdst(regdst_n), .immext(immext_n), .pcsrc(pcsrc_n), .alucontrol(alucontrol_n),
    .illegal(illegal_n), .state(state_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic test_reset();
    #1;
    n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_cmp++; if ({irwrite, pcen} !== 2'b11) begin n_err++; $display("FAIL reset_ir_pc: got %b expected 11", {irwrite, pcen}); end
    n_cmp++; if ({iord, alusrca, alusrcb, alucontrol, pcsrc} !== 9'b0_0_01_010_00) begin
      n_err++; $display("FAIL reset_mux: got %b expected 000101000", {iord, alusrca, alusrcb, alucontrol, pcsrc}); end
    n_cmp++; if ({memwrite, regwrite, memtoreg, regdst, immext, illegal} !== 6'b0) begin
      n_err++; $display("FAIL reset_strobes: got %b expected 000000", {memwrite, regwrite, memtoreg, regdst, immext, illegal}); end
  endtask

  task automatic test_rtype();
    logic [3:0] es [4] = '{4'd1, 4'd6, 4'd7, 4'd0};
    #10 reset = 1'b1;
    #1;
    n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL rtype_release: got %0d expected 0", state); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_cmp++; if (state !== es[i]) begin n_err++; $display("FAIL rtype_state step %0d: got %0d expected %0d", i, state, es[i]); end
      if (es[i] == 4'd6) begin
        n_cmp++; if ({alusrca, alusrcb, alucontrol} !== 6'b1_00_010) begin
          n_err++; $display("FAIL rtype_ex: got %b expected 100010", {alusrca, alusrcb, alucontrol}); end
      end
      if (es[i] == 4'd7) begin
        n_cmp++; if ({regwrite, regdst, memtoreg} !== 3'b110) begin
          n_err++; $display("FAIL rtype_wb: got %b expected 110", {regwrite, regdst, memtoreg}); end
      end
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0] es  [10] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    logic       rd  [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       eir [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    op = 6'h23;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = rd[i];
      #1;
      n_cmp++; if (state !== es[i]) begin n_err++; $display("FAIL lw_state step %0d: got %0d expected %0d", i, state, es[i]); end
      n_cmp++; if ({irwrite, pcen} !== {eir[i], eir[i]}) begin
        n_err++; $display("FAIL lw_irwrite step %0d: got %b expected %b", i, {irwrite, pcen}, {eir[i], eir[i]}); end
      if (es[i] == 4'd3) begin
        n_cmp++; if ({iord, regwrite} !== 2'b10) begin n_err++; $display("FAIL lw_memrd step %0d: got %b expected 10", i, {iord, regwrite}); end
      end
      if (es[i] == 4'd4) begin
        n_cmp++; if ({regwrite, memtoreg, regdst} !== 3'b110) begin
          n_err++; $display("FAIL lw_memwb: got %b expected 110", {regwrite, memtoreg, regdst}); end
      end
    end
  endtask

  task automatic test_branch();
    op = 6'h04; zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (i == 1) begin
        n_cmp++; if (state !== 4'd8) begin n_err++; $display("FAIL beq_state: got %0d expected 8", state); end
        n_cmp++; if ({pcen, pcsrc, alucontrol, alusrca, alusrcb} !== 9'b1_01_110_1_00) begin
          n_err++; $display("FAIL beq_taken: got %b expected 101110100", {pcen, pcsrc, alucontrol, alusrca, alusrcb}); end
        zero = 1'b0; #1;
        n_cmp++; if (pcen !== 1'b0) begin n_err++; $display("FAIL beq_not_taken: got %b expected 0", pcen); end
      end
    end
    n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL beq_done: got %0d expected 0", state); end
    op = 6'h05; zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (i == 1) begin
        n_cmp++; if (state !== 4'd12) begin n_err++; $display("FAIL bne_state: got %0d expected 12", state); end
        n_cmp++; if ({pcen, pcsrc} !== 3'b0_01) begin n_err++; $display("FAIL bne_zero1: got %b expected 001", {pcen, pcsrc}); end
        zero = 1'b0; #1;
        n_cmp++; if (pcen !== 1'b1) begin n_err++; $display("FAIL bne_zero0: got %b expected 1", pcen); end
      end
    end
    n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL bne_done: got %0d expected 0", state); end
    op = 6'h02;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (i == 1) begin
        n_cmp++; if ({state, pcen, pcsrc} !== {4'd11, 1'b1, 2'b10}) begin
          n_err++; $display("FAIL j_ex: got %b expected 1011110", {state, pcen, pcsrc}); end
      end
    end
    n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL j_done: got %0d expected 0", state); end
  endtask

  task automatic test_imm();
    logic [5:0] ops  [3] = '{6'h0c, 6'h0a, 6'h0d};
    logic [2:0] ealu [3] = '{3'b000, 3'b111, 3'b001};
    logic       eimm [3] = '{1'b1, 1'b0, 1'b1};
    logic [3:0] es   [4] = '{4'd1, 4'd9, 4'd10, 4'd0};
    for (int k = 0; k < 3; k++) begin
      op = ops[k];
      for (int i = 0; i < 4; i++) begin
        @(negedge clk); #1;
        n_cmp++; if (state !== es[i]) begin n_err++; $display("FAIL imm_state op %h step %0d: got %0d expected %0d", ops[k], i, state, es[i]); end
        if (es[i] == 4'd9) begin
          n_cmp++; if ({alucontrol, immext, alusrca, alusrcb} !== {ealu[k], eimm[k], 1'b1, 2'b10}) begin
            n_err++; $display("FAIL imm_ex op %h: got %b expected %b", ops[k], {alucontrol, immext, alusrca, alusrcb}, {ealu[k], eimm[k], 1'b1, 2'b10}); end
        end
        if (es[i] == 4'd10) begin
          n_cmp++; if ({regwrite, regdst, memtoreg} !== 3'b100) begin
            n_err++; $display("FAIL imm_wb op %h: got %b expected 100", ops[k], {regwrite, regdst, memtoreg}); end
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops [2] = '{6'h3f, 6'h00};
    funct = 6'h00;
    for (int k = 0; k < 2; k++) begin
      op = ops[k];
      @(negedge clk); #1;
      n_cmp++; if ({state, illegal} !== {4'd1, 1'b1}) begin
        n_err++; $display("FAIL illegal_decode op %h: got state %0d illegal %b expected state 1 illegal 1", ops[k], state, illegal); end
      @(negedge clk); #1;
      n_cmp++; if ({state, illegal} !== {4'd0, 1'b0}) begin
        n_err++; $display("FAIL illegal_return op %h: got state %0d illegal %b expected state 0 illegal 0", ops[k], state, illegal); end
    end
    funct = 6'h20;
    op = 6'h05;
    @(negedge clk); reset = 1'b0; #1; reset = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if ({state_n, illegal_n} !== {4'd1, 1'b1}) begin
      n_err++; $display("FAIL noext_bne_decode: got state %0d illegal %b expected state 1 illegal 1", state_n, illegal_n); end
    n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL ext_bne_legal: got illegal %b expected 0", illegal); end
    @(negedge clk); #1;
    n_cmp++; if ({state_n, state} !== {4'd0, 4'd12}) begin
      n_err++; $display("FAIL noext_bne_next: got noext %0d ext %0d expected noext 0 ext 12", state_n, state); end
  endtask

  task automatic test_reset_midwrite();
    logic [3:0] es [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
    op = 6'h2b; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_cmp++; if (state !== es[i]) begin n_err++; $display("FAIL sw_state step %0d: got %0d expected %0d", i, state, es[i]); end
      if (i == 2) mem_ready = 1'b0;
    end
    n_cmp++; if ({memwrite, iord} !== 2'b11) begin n_err++; $display("FAIL sw_memwr: got %b expected 11", {memwrite, iord}); end
    @(negedge clk); #1;
    n_cmp++; if ({state, memwrite} !== {4'd5, 1'b1}) begin
      n_err++; $display("FAIL sw_wait: got state %0d memwrite %b expected state 5 memwrite 1", state, memwrite); end
    #2 reset = 1'b0; #1;
    n_cmp++; if ({state, memwrite, regwrite} !== {4'd0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL async_reset: got state %0d memwrite %b regwrite %b expected state 0 memwrite 0 regwrite 0", state, memwrite, regwrite); end
    @(negedge clk); reset = 1'b1; #1;
    @(negedge clk); #1;
    n_cmp++; if ({state, irwrite, memwrite} !== {4'd0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL fetch_wait: got state %0d irwrite %b memwrite %b expected state 0 irwrite 0 memwrite 0", state, irwrite, memwrite); end
    mem_ready = 1'b1; #1;
    n_cmp++; if ({irwrite, pcen} !== 2'b11) begin n_err++; $display("FAIL fetch_ready: got %b expected 11", {irwrite, pcen}); end
    @(negedge clk); #1;
    n_cmp++; if (state !== 4'd1) begin n_err++; $display("FAIL post_reset_decode: got %0d expected 1", state); end
  endtask

  initial begin
    reset = 1'b0; op = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b1;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch();
    test_imm();
    test_illegal();
    test_reset_midwrite();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
